// File: rtl/clt_norm_accum.sv
// Central-limit accumulator: sums NUM_SUM multiplier products, rounds/shifts/saturates into one normal sample.
// Optional macro CLT_SAT_FLAG_EN adds the out_sat port flagging clamped samples.
module clt_norm_accum #(
    parameter int PROD_W  = 25,
    parameter int NUM_SUM = 12,
    parameter int SHIFT   = 9,
    parameter int OUT_W   = 16,
    parameter int MUL_LAT = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mul_ce,
    input  logic [PROD_W-1:0] mul_dout,
    output logic              out_valid,
    input  logic              out_ready,
`ifdef CLT_SAT_FLAG_EN
    output logic              out_sat,
`endif
    output logic [OUT_W-1:0]  out_data
);

    localparam int CNT_W = $clog2(NUM_SUM);
    localparam int ACC_W = PROD_W + CNT_W;
    // One guard bit so adding the rounding half can never wrap.
    localparam int RND_W = ACC_W + 1;

    localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(NUM_SUM - 1);
    localparam logic [RND_W-1:0]        RND_HALF = {{(RND_W-1){1'b0}}, 1'b1} << (SHIFT - 1);
    localparam logic signed [RND_W-1:0] SAT_MAX  = {{(RND_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [RND_W-1:0] SAT_MIN  = {{(RND_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic [MUL_LAT-1:0]        r_vsr;
    logic signed [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]          r_cnt;
    logic                      r_out_valid;
    logic [OUT_W-1:0]          r_out_data;

    logic                      w_stall;
    logic                      w_accept;
    logic                      w_consume;
    logic                      w_final;
    logic signed [ACC_W-1:0]   w_prod_ext;
    logic signed [ACC_W-1:0]   w_sum;
    logic signed [RND_W-1:0]   w_rnd;
    logic signed [RND_W-1:0]   w_shifted;
    logic                      w_sat_hi;
    logic                      w_sat_lo;
    logic [OUT_W-1:0]          w_sample;

    assign w_stall    = r_out_valid && !out_ready;
    assign mul_ce     = !w_stall;
    assign in_ready   = !w_stall;
    assign w_accept   = in_valid && in_ready;
    assign w_consume  = mul_ce && r_vsr[MUL_LAT-1];
    assign w_final    = w_consume && (r_cnt == CNT_LAST);

    assign w_prod_ext = {{(ACC_W-PROD_W){mul_dout[PROD_W-1]}}, mul_dout};
    assign w_sum      = r_acc + w_prod_ext;
    assign w_rnd      = {w_sum[ACC_W-1], w_sum} + RND_HALF;
    assign w_shifted  = w_rnd >>> SHIFT;
    assign w_sat_hi   = w_shifted > SAT_MAX;
    assign w_sat_lo   = w_shifted < SAT_MIN;

    // NOTE: give every always_comb output a value on every path so no latch is inferred.
    always_comb begin
        w_sample = w_shifted[OUT_W-1:0];
        if (w_sat_hi) begin
            w_sample = {1'b0, {(OUT_W-1){1'b1}}};
        end else if (w_sat_lo) begin
            w_sample = {1'b1, {(OUT_W-1){1'b0}}};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vsr       <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            if (mul_ce) begin
                r_vsr <= (r_vsr << 1) | MUL_LAT'(w_accept);
            end
            if (w_consume) begin
                if (w_final) begin
                    r_acc <= '0;
                    r_cnt <= '0;
                end else begin
                    r_acc <= w_sum;
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
            // A new sample may overwrite an accepted one; a stall blocks w_final entirely.
            if (w_final) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_sample;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

`ifdef CLT_SAT_FLAG_EN
    logic r_sat;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sat <= 1'b0;
        end else if (w_final) begin
            r_sat <= w_sat_hi || w_sat_lo;
        end
    end

    assign out_sat = r_sat;
`endif

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

endmodule

// File: tb/tb_clt_norm_accum.sv
// Scoreboard bench for clt_norm_accum: a ce-gated multiplier pipeline model feeds products,
// a sum/round/clamp reference predicts samples, and a monitor pops and compares on each handshake.
module tb_clt_norm_accum;

    localparam int PROD_W  = 25;
    localparam int NUM_SUM = 12;
    localparam int SHIFT   = 9;
    localparam int OUT_W   = 16;
    localparam int MUL_LAT = 3;

    typedef struct {
        longint data;
        bit     sat;
        bit     timed;
        longint cyc;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              mul_ce;
    logic [PROD_W-1:0] mul_dout;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [OUT_W-1:0]  out_data;
`ifdef CLT_SAT_FLAG_EN
    logic              out_sat;
`endif

    logic [PROD_W-1:0] prod_in = '0;
    logic [PROD_W-1:0] p0, p1, p2;

    int     checks = 0;
    int     failures = 0;
    longint cyc = 0;
    logic   rst_q = 1'b1;
    int     ready_mode = 0;   // 0: always ready, 1: random, 2: never ready
    bit     timed = 1'b0;
    longint part_sum = 0;
    int     part_cnt = 0;
    exp_t   sb[$];

    clt_norm_accum #(
        .PROD_W(PROD_W), .NUM_SUM(NUM_SUM), .SHIFT(SHIFT), .OUT_W(OUT_W), .MUL_LAT(MUL_LAT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .mul_ce   (mul_ce),
        .mul_dout (mul_dout),
        .out_valid(out_valid),
        .out_ready(out_ready),
`ifdef CLT_SAT_FLAG_EN
        .out_sat  (out_sat),
`endif
        .out_data (out_data)
    );

    always #5 clk = ~clk;

    // Multiplier stand-in: MUL_LAT ce-qualified stages carrying the product chosen by the stimulus.
    always @(posedge clk) begin
        if (mul_ce) begin
            p0 <= prod_in;
            p1 <= p0;
            p2 <= p1;
        end
    end
    assign mul_dout = p2;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= reset;
    end

    always begin
        @(negedge clk);
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: floor((sum + half) / 2^SHIFT), then clamp to the signed output range.
    task automatic model_add(input longint p, input longint acc_cyc);
        exp_t   e;
        longint r;
        longint hi = (longint'(1) << (OUT_W - 1)) - 1;
        longint lo = -(longint'(1) << (OUT_W - 1));
        part_sum += p;
        part_cnt++;
        if (part_cnt == NUM_SUM) begin
            r = (part_sum + (longint'(1) << (SHIFT - 1))) >>> SHIFT;
            e.sat   = (r > hi) || (r < lo);
            e.data  = (r > hi) ? hi : (r < lo) ? lo : r;
            e.timed = timed;
            e.cyc   = acc_cyc + MUL_LAT + 1;
            sb.push_back(e);
            part_sum = 0;
            part_cnt = 0;
        end
    endtask

    task automatic send(input longint p, input int bubbles);
        bit done = 1'b0;
        logic [63:0] pv = p;
        for (int t = 0; t < 500 && !done; t++) begin
            @(negedge clk);
            in_valid = 1'b1;
            prod_in  = pv[PROD_W-1:0];
            #1;
            if (in_ready) begin
                model_add(p, cyc);
                done = 1'b1;
            end
        end
        if (!done) check("send_timeout", 0, 1);
        for (int b = 0; b < bubbles; b++) begin
            @(negedge clk);
            in_valid = 1'b0;
            prod_in  = PROD_W'($urandom);
        end
    endtask

    task automatic drain();
        int n = 0;
        @(negedge clk);
        in_valid = 1'b0;
        while ((sb.size() != 0 || out_valid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) check("drain_timeout", n, 0);
    endtask

    task automatic burst(input longint p, input int count, input int bubbles);
        for (int i = 0; i < count; i++) send(p, bubbles);
    endtask

    // Monitor: reset values, ce/ready relation, hold-under-stall and scoreboard pops.
    initial begin
        bit          prev_stall = 1'b0;
        logic [OUT_W-1:0] prev_data = '0;
        exp_t        e;
        forever begin
            @(negedge clk);
            #4;
            if (rst_q) begin
                check("reset_out_valid", out_valid, 0);
                check("reset_out_data", out_data, 0);
`ifdef CLT_SAT_FLAG_EN
                check("reset_out_sat", out_sat, 0);
`endif
                prev_stall = 1'b0;
            end else begin
                check("mul_ce", mul_ce, !(out_valid && !out_ready));
                check("in_ready", in_ready, !(out_valid && !out_ready));
                if (prev_stall) begin
                    check("hold_valid", out_valid, 1);
                    check("hold_data", out_data, prev_data);
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        check("unexpected_sample", $signed(out_data), 99999);
                    end else begin
                        e = sb.pop_front();
                        check("sample_data", longint'($signed(out_data)), e.data);
`ifdef CLT_SAT_FLAG_EN
                        check("sample_sat", out_sat, e.sat);
`endif
                        if (e.timed) check("sample_latency", cyc, e.cyc);
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;

        timed = 1'b1;
        burst(512, 12, 0);                    drain();
        burst(-512, 12, 0);                   drain();
        send(256, 0);  burst(0, 11, 0);       drain();
        send(255, 0);  burst(0, 11, 0);       drain();
        burst(8355585, 12, 0);                drain();
        burst(-8355840, 12, 0);               drain();
        burst(512, 12, 1);                    drain();   // alternating bubbles

        // Stall: hold out_ready low for 5 cycles with out_valid up while operands keep coming.
        timed = 1'b0;
        ready_mode = 2;
        fork
            burst(512, 24, 0);
            begin
                int n = 0;
                while (!out_valid && n < 200) begin
                    @(negedge clk);
                    n++;
                end
                if (n >= 200) check("stall_wait_timeout", n, 0);
                repeat (5) @(negedge clk);
                #2 ready_mode = 0;
            end
        join
        drain();

        // Reset mid-sum discards the partial accumulation and in-flight operands.
        timed = 1'b1;
        burst(777, 5, 0);
        repeat (6) @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b1;
        part_sum = 0;
        part_cnt = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        burst(1024, 12, 0);                   drain();

        // Random products, bubbles and back-pressure.
        timed = 1'b0;
        ready_mode = 1;
        for (int s = 0; s < 40; s++) begin
            for (int i = 0; i < NUM_SUM; i++) begin
                logic [PROD_W-1:0] raw = PROD_W'($urandom);
                longint p = (s % 3 == 0) ? longint'($signed(raw))
                                         : longint'($urandom_range(0, 4000)) - 2000;
                send(p, (($urandom & 3) == 0) ? 1 : 0);
            end
        end
        ready_mode = 0;
        drain();
        check("scoreboard_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
